keypad_scanner: RTL and testbench

- Reads a 4x4 matrix keypad. It drives the column lines, samples the row lines, debounces the result and emits one key code per press.
- Runs on `clock_50m`. It advances only on `scan_tick`, a one-cycle enable strobe at the keypad scan rate, instead of running on a derived clock.
- It is the consuming end of the keypad scan-clock interface: the divider produces the scan rate, and this block uses it to read the switches.
- `key_code` / `key_valid` feed downstream control and FND display logic.

---
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and key-code output bundle for keypad_scanner.
// master is the scanner side, slave is the matrix / consumer side.
interface keypad_scanner_if;
  logic       scan_tick;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  scan_tick,
    input  key_row,
    output key_col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output scan_tick,
    output key_row,
    input  key_col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, debounced press/release.
// Advances only on scan_tick; emits one key_valid pulse per press.
module keypad_scanner #(
  parameter int DEB_TICKS = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clock_50m,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_e;

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_TICKS);

  state_e           st_q, st_d;
  logic [3:0]       sy1_q, row_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       first_low;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             cand_low;

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      sy1_q   <= 4'b1111;
      row_s_q <= 4'b1111;
    end else begin
      sy1_q   <= kp.key_row;
      row_s_q <= sy1_q;
    end
  end

  assign cand_low = ~row_s_q[row_q];
  assign cnt_inc  = cnt_q + 1'b1;

  // Several rows low at once: the lowest index is tracked.
  always_comb begin
    first_low = 2'd3;
    priority case (1'b0)
      row_s_q[0]: first_low = 2'd0;
      row_s_q[1]: first_low = 2'd1;
      row_s_q[2]: first_low = 2'd2;
      default:    first_low = 2'd3;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (kp.scan_tick) begin
      unique case (st_q)
        SCAN: begin
          if (&row_s_q) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d = first_low;
            cnt_d = CNT_W'(1);
            st_d  = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              st_d    = PRESSED;
            end
          end else begin
            cnt_d = '0;
            col_d = col_q + 2'd1;
            st_d  = SCAN;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              held_d = 1'b0;
              cnt_d  = '0;
              col_d  = col_q + 2'd1;
              st_d   = SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: st_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      st_q    <= SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign kp.key_col   = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner.
// A tick-level keypad model predicts presses; a monitor checks key_valid.
module tb_keypad_scanner;

  localparam int DEB = 4;

  logic clk;
  logic rst;
  logic [3:0] pr [4];

  int total = 0;
  int bad   = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.DEB_TICKS(DEB), .CNT_W(3)) dut (
    .clock_50m (clk),
    .rst       (rst),
    .kp        (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a row reads 0 when a closed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      kif.key_row[r] = ~|(pr[r] & ~kif.key_col);
  end

  // Reference: which column is scanned, which key is being tracked,
  // how many consecutive agreeing samples have been seen.
  int m_col;
  int m_phase;
  int m_row;
  int m_streak;
  bit m_held;
  logic [3:0] m_code;
  int expq[$];

  task automatic model_reset();
    m_col = 0; m_phase = 0; m_row = 0; m_streak = 0;
    m_held = 0; m_code = 4'd0;
    expq.delete();
  endtask

  task automatic model_step();
    bit low [4];
    bit any;
    any = 0;
    for (int r = 0; r < 4; r++) begin
      low[r] = pr[r][m_col];
      any = any | low[r];
    end
    if (m_phase == 0) begin
      if (!any) m_col = (m_col + 1) % 4;
      else begin
        m_row = 3;
        for (int r = 3; r >= 0; r--) if (low[r]) m_row = r;
        m_streak = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (low[m_row]) begin
        m_streak++;
        if (m_streak == DEB) begin
          m_code = 4'(m_row * 4 + m_col);
          expq.push_back(m_row * 4 + m_col);
          m_held = 1;
          m_streak = 0;
          m_phase = 2;
        end
      end else begin
        m_streak = 0;
        m_col = (m_col + 1) % 4;
        m_phase = 0;
      end
    end else begin
      m_streak = low[m_row] ? 0 : m_streak + 1;
      if (m_streak == DEB) begin
        m_held = 0;
        m_streak = 0;
        m_col = (m_col + 1) % 4;
        m_phase = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic tick_once();
    logic [3:0] ecol;
    repeat (2) @(negedge clk);
    kif.scan_tick = 1'b1;
    model_step();
    @(negedge clk);
    kif.scan_tick = 1'b0;
    repeat (4) @(negedge clk);
    ecol = 4'b1111;
    ecol[m_col] = 1'b0;
    chk("key_col", kif.key_col, ecol);
    chk("key_held", {3'b0, kif.key_held}, {3'b0, m_held});
    chk("key_code", kif.key_code, m_code);
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pr[r] = 4'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_col", kif.key_col, 4'b1110);
    chk("rst_code", kif.key_code, 4'd0);
    chk("rst_held", {3'b0, kif.key_held}, 4'd0);
    chk("rst_valid", {3'b0, kif.key_valid}, 4'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && kif.key_valid) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL valid_pulse actual=unexpected code %0d required=no pulse", kif.key_code);
      end else begin
        int e;
        e = expq.pop_front();
        if (kif.key_code !== 4'(e)) begin
          bad++;
          $display("FAIL pulse_code actual=%0d required=%0d", kif.key_code, e);
        end
      end
    end
  end

  int guard;

  initial begin
    rst = 1'b0;
    kif.scan_tick = 1'b0;
    clear_keys();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_col", kif.key_col, 4'b1110);
    chk("reset_code", kif.key_code, 4'd0);
    rst = 1'b1;

    // Idle scan, reset mid-scan, then idle again.
    repeat (3) tick_once();
    async_reset();
    repeat (8) tick_once();

    // Clean press of row 2 / column 1 -> code 9, then release.
    pr[2][1] = 1'b1;
    repeat (14) tick_once();
    chk("clean_held", {3'b0, kif.key_held}, 4'd1);
    chk("clean_col", kif.key_col, 4'b1101);
    // Release with glitches.
    pr[2][1] = 1'b0;
    repeat (2) tick_once();
    pr[2][1] = 1'b1;
    tick_once();
    pr[2][1] = 1'b0;
    repeat (6) tick_once();

    // Multi-key in column 0: rows 1 and 3, then row 1 released.
    pr[1][0] = 1'b1;
    pr[3][0] = 1'b1;
    repeat (12) tick_once();
    pr[1][0] = 1'b0;
    repeat (16) tick_once();
    clear_keys();
    repeat (8) tick_once();

    // Press again and reset between edges while held.
    pr[0][3] = 1'b1;
    guard = 0;
    while (!m_held && guard < 40) begin
      tick_once();
      guard++;
    end
    chk("press_before_rst", {3'b0, kif.key_held}, 4'd1);
    async_reset();
    clear_keys();
    repeat (4) tick_once();

    // Random key activity including bounces and multi-key.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r, c, n;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        pr[r][c] = ~pr[r][c];
        n = 0;
        for (int a = 0; a < 4; a++) n += $countones(pr[a]);
        if (n > 2) clear_keys();
      end
      tick_once();
    end
    clear_keys();
    repeat (12) tick_once();

    repeat (4) @(negedge clk);
    chk("queue_empty", 4'(expq.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
